pipe_ctrl_stage: RTL and testbench

Registered decode-and-hazard control stage for the pipelined RISC-V core. It decodes the ID-stage opcode into a control bundle and holds that bundle in the ID/EX control register. It detects load-use hazards and inserts one bubble. It freezes the front end while the data cache reports a miss, and squashes the ID/EX stage on a taken branch. Optional jump support and saturating stall/bubble performance counters are parameter-selected.

---
 rtl/pipe_ctrl_pkg.sv | 44 ++++
 rtl/pipe_ctrl_decode.sv | 68 ++++++
 rtl/pipe_ctrl_stage.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl_stage.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the ID/EX decode-and-hazard stage.
//   - opcode constants (RV32I subset handled by the stage)
//   - ALU-op and write-back-select encodings
//   - ctrl_bundle_t: the control bundle carried in the ID/EX register
//   - CTRL_BUBBLE: the all-zero bundle used for bubbles
//   - state_t: stage FSM states
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RFUNC = 2'b10;
  localparam logic [1:0] ALU_IFUNC = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] wb_sel;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: purely combinational opcode decoder.
// Ports:
//   op_i       - opcode of the instruction in ID
//   ctrl_o     - decoded control bundle (CTRL_BUBBLE for unknown opcodes)
//   illegal_o  - opcode not recognised (JAL/JALR count as unknown when JUMP_EN = 0)
//   use_rs1_o  - instruction reads rs1 (everything except JAL)
//   use_rs2_o  - instruction reads rs2 (R-type, SW, BEQ)
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int JUMP_EN = 0
) (
  input  logic [6:0]   op_i,
  output ctrl_bundle_t ctrl_o,
  output logic         illegal_o,
  output logic         use_rs1_o,
  output logic         use_rs2_o
);

  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    illegal_o = 1'b0;
    case (op_i)
      OP_R: begin
        ctrl_o.alu_op    = ALU_RFUNC;
        ctrl_o.reg_write = 1'b1;
      end
      OP_I: begin
        ctrl_o.alu_op    = ALU_IFUNC;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.wb_sel    = WB_MEM;
      end
      OP_SW: begin
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.alu_op = ALU_SUB;
        ctrl_o.branch = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        if (JUMP_EN != 0) begin
          ctrl_o.alu_op    = ALU_ADD;
          ctrl_o.alu_src   = (op_i == OP_JALR);
          ctrl_o.reg_write = 1'b1;
          ctrl_o.jump      = 1'b1;
          ctrl_o.wb_sel    = WB_PC4;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // JAL has no rs1 field; its bits [19:15] are immediate and must not alias a register.
  assign use_rs1_o = (op_i != OP_JAL);
  assign use_rs2_o = (op_i == OP_R) || (op_i == OP_SW) || (op_i == OP_BEQ);

endmodule

// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage: ID/EX control register with load-use hazard detection,
// data-cache stall freeze, branch flush and saturating performance counters.
// Ports:
//   clk_i, rst_n_i                    - clock, async active-low reset
//   id_op_i, id_rs1_i, id_rs2_i, id_rd_i - ID-stage instruction fields
//   mem_stall_i                       - data cache busy, hold the pipeline
//   flush_i                           - taken branch/jump, squash ID
//   ex_*_o                            - registered ID/EX control bundle and rd
//   pc_write_o, ifid_write_o          - front-end write enables (combinational)
//   hazard_o                          - load-use hazard this cycle (combinational)
//   illegal_o                         - sticky unknown-opcode flag
//   stall_cnt_o, bubble_cnt_o         - saturating event counters
//   state_dbg_o                       - current FSM state (0 = RUN, 1 = HOLD)
//
// Handshake: there is no valid/ready pair here; pc_write_o/ifid_write_o low
// means the front end must keep its current PC and IF/ID contents this cycle.
module pipe_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16,
  parameter int JUMP_EN = 0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [6:0]         id_op_i,
  input  logic [REG_AW-1:0]  id_rs1_i,
  input  logic [REG_AW-1:0]  id_rs2_i,
  input  logic [REG_AW-1:0]  id_rd_i,
  input  logic               mem_stall_i,
  input  logic               flush_i,
  output logic [ALUOP_W-1:0] ex_alu_op_o,
  output logic               ex_alu_src_o,
  output logic               ex_reg_write_o,
  output logic               ex_mem_read_o,
  output logic               ex_mem_write_o,
  output logic               ex_branch_o,
  output logic               ex_jump_o,
  output logic [1:0]         ex_wb_sel_o,
  output logic [REG_AW-1:0]  ex_rd_o,
  output logic               pc_write_o,
  output logic               ifid_write_o,
  output logic               hazard_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o,
  output logic               state_dbg_o
);

  state_t             r_state, w_state_nxt;
  ctrl_bundle_t       w_dec_ctrl, r_ex_ctrl, w_ex_ctrl_nxt;
  logic [REG_AW-1:0]  r_ex_rd, w_ex_rd_nxt;
  logic               w_dec_illegal, w_use_rs1, w_use_rs2;
  logic               w_hazard_raw, w_hazard, w_front_en;
  logic               w_load, w_bubble, w_set_illegal;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_stall_cnt, r_bubble_cnt;

  pipe_ctrl_decode #(.JUMP_EN(JUMP_EN)) u_decode (
    .op_i      (id_op_i),
    .ctrl_o    (w_dec_ctrl),
    .illegal_o (w_dec_illegal),
    .use_rs1_o (w_use_rs1),
    .use_rs2_o (w_use_rs2)
  );

  // Load in EX whose destination is read by ID; x0 never creates a dependency.
  assign w_hazard_raw = r_ex_ctrl.mem_read && (r_ex_rd != '0) &&
                        ((w_use_rs1 && (r_ex_rd == id_rs1_i)) ||
                         (w_use_rs2 && (r_ex_rd == id_rs2_i)));
  // A flush already inserts the bubble, so the hazard is not reported on top of it.
  assign w_hazard     = w_hazard_raw && !flush_i;

  // The release cycle of a stall is still spent in HOLD, so the front end is
  // frozen for one cycle beyond the last mem_stall_i cycle.
  assign w_front_en = !rst_n_i || !(mem_stall_i || w_hazard || (r_state == ST_HOLD));

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (mem_stall_i)  w_state_nxt = ST_HOLD;
      ST_HOLD: if (!mem_stall_i) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // FSM: outputs (ID/EX load selection)
  always_comb begin
    w_load        = (r_state == ST_RUN) && !mem_stall_i;
    w_bubble      = flush_i || w_hazard || w_dec_illegal;
    w_ex_ctrl_nxt = r_ex_ctrl;
    w_ex_rd_nxt   = r_ex_rd;
    if (w_load) begin
      if (w_bubble) begin
        w_ex_ctrl_nxt = CTRL_BUBBLE;
        w_ex_rd_nxt   = '0;
      end else begin
        w_ex_ctrl_nxt = w_dec_ctrl;
        w_ex_rd_nxt   = id_rd_i;
      end
    end
    // Only an unknown opcode that actually gets past flush and hazard is flagged.
    w_set_illegal = w_load && !flush_i && !w_hazard && w_dec_illegal;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ex_ctrl    <= CTRL_BUBBLE;
      r_ex_rd      <= '0;
      r_illegal    <= 1'b0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_ex_ctrl <= w_ex_ctrl_nxt;
      r_ex_rd   <= w_ex_rd_nxt;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (!w_front_en && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_load && w_bubble && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign ex_alu_op_o    = ALUOP_W'(r_ex_ctrl.alu_op);
  assign ex_alu_src_o   = r_ex_ctrl.alu_src;
  assign ex_reg_write_o = r_ex_ctrl.reg_write;
  assign ex_mem_read_o  = r_ex_ctrl.mem_read;
  assign ex_mem_write_o = r_ex_ctrl.mem_write;
  assign ex_branch_o    = r_ex_ctrl.branch;
  assign ex_jump_o      = r_ex_ctrl.jump;
  assign ex_wb_sel_o    = r_ex_ctrl.wb_sel;
  assign ex_rd_o        = r_ex_rd;
  assign pc_write_o     = w_front_en;
  assign ifid_write_o   = w_front_en;
  assign hazard_o       = w_hazard;
  assign illegal_o      = r_illegal;
  assign stall_cnt_o    = r_stall_cnt;
  assign bubble_cnt_o   = r_bubble_cnt;
  assign state_dbg_o    = (r_state == ST_HOLD);

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Bench for pipe_ctrl_stage. Two instances share the stimulus:
//   d0: JUMP_EN = 0, CNT_W = 16   d1: JUMP_EN = 1, CNT_W = 4 (saturates quickly)
module tb_pipe_ctrl_stage;

  localparam logic [6:0] R    = 7'b0110011;
  localparam logic [6:0] I    = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [6:0] id_op;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_stall, id_flush;

  logic [1:0]  d0_alu, d1_alu, d0_wb, d1_wb;
  logic        d0_src, d0_rw, d0_mr, d0_mw, d0_br, d0_jp;
  logic        d1_src, d1_rw, d1_mr, d1_mw, d1_br, d1_jp;
  logic [4:0]  d0_rd, d1_rd;
  logic        d0_pcw, d0_ifw, d0_hz, d0_ill, d0_st;
  logic        d1_pcw, d1_ifw, d1_hz, d1_ill, d1_st;
  logic [15:0] d0_sc, d0_bc;
  logic [3:0]  d1_sc, d1_bc;

  pipe_ctrl_stage #(.REG_AW(5), .ALUOP_W(2), .CNT_W(16), .JUMP_EN(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .id_op_i(id_op), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rd_i(id_rd), .mem_stall_i(id_stall), .flush_i(id_flush),
    .ex_alu_op_o(d0_alu), .ex_alu_src_o(d0_src), .ex_reg_write_o(d0_rw),
    .ex_mem_read_o(d0_mr), .ex_mem_write_o(d0_mw), .ex_branch_o(d0_br), .ex_jump_o(d0_jp),
    .ex_wb_sel_o(d0_wb), .ex_rd_o(d0_rd), .pc_write_o(d0_pcw), .ifid_write_o(d0_ifw),
    .hazard_o(d0_hz), .illegal_o(d0_ill), .stall_cnt_o(d0_sc), .bubble_cnt_o(d0_bc),
    .state_dbg_o(d0_st));

  pipe_ctrl_stage #(.REG_AW(5), .ALUOP_W(2), .CNT_W(4), .JUMP_EN(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .id_op_i(id_op), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rd_i(id_rd), .mem_stall_i(id_stall), .flush_i(id_flush),
    .ex_alu_op_o(d1_alu), .ex_alu_src_o(d1_src), .ex_reg_write_o(d1_rw),
    .ex_mem_read_o(d1_mr), .ex_mem_write_o(d1_mw), .ex_branch_o(d1_br), .ex_jump_o(d1_jp),
    .ex_wb_sel_o(d1_wb), .ex_rd_o(d1_rd), .pc_write_o(d1_pcw), .ifid_write_o(d1_ifw),
    .hazard_o(d1_hz), .illegal_o(d1_ill), .stall_cnt_o(d1_sc), .bubble_cnt_o(d1_bc),
    .state_dbg_o(d1_st));

  typedef struct {
    logic [1:0] alu_op;
    logic       alu_src, reg_write, mem_read, mem_write, branch, jump;
    logic [1:0] wb_sel;
    logic [4:0] rd;
  } ex_t;

  typedef struct {
    ex_t         ex;
    logic        pcw, ifw, hz, ill, st;
    logic [15:0] sc, bc;
  } obs_t;

  obs_t obs[2];
  always_comb begin
    obs[0].ex = '{d0_alu, d0_src, d0_rw, d0_mr, d0_mw, d0_br, d0_jp, d0_wb, d0_rd};
    obs[0].pcw = d0_pcw; obs[0].ifw = d0_ifw; obs[0].hz = d0_hz;
    obs[0].ill = d0_ill; obs[0].st = d0_st; obs[0].sc = d0_sc; obs[0].bc = d0_bc;
    obs[1].ex = '{d1_alu, d1_src, d1_rw, d1_mr, d1_mw, d1_br, d1_jp, d1_wb, d1_rd};
    obs[1].pcw = d1_pcw; obs[1].ifw = d1_ifw; obs[1].hz = d1_hz;
    obs[1].ill = d1_ill; obs[1].st = d1_st;
    obs[1].sc = {12'd0, d1_sc}; obs[1].bc = {12'd0, d1_bc};
  end

  // ---------------- scoreboard counters ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behaviour: each instance has an EX slot, a "frozen by cache" flag, a sticky
  // illegal flag and two saturating event counts.
  ex_t m_ex[2];
  bit  m_frozen[2];
  bit  m_ill[2];
  int  m_sc[2], m_bc[2];
  int  m_je[2]  = '{0, 1};
  int  m_max[2] = '{65535, 15};
  bit  m_hz[2], m_pcw[2];

  function automatic ex_t zero_ex();
    ex_t e;
    e = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0};
    return e;
  endfunction

  // Decode table; returns 1 for a recognised instruction.
  function automatic bit m_decode(input logic [6:0] op, input int je, input logic [4:0] rd,
                                  output ex_t e);
    e = zero_ex();
    case (op)
      R:   begin e = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, rd}; return 1'b1; end
      I:   begin e = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, rd}; return 1'b1; end
      LW:  begin e = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, rd}; return 1'b1; end
      SW:  begin e = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, rd}; return 1'b1; end
      BEQ: begin e = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, rd}; return 1'b1; end
      JAL, JALR: begin
        if (je != 0) begin
          e = '{2'b00, (op == JALR), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, rd};
          return 1'b1;
        end
        return 1'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_hazard(input int i);
    bit reads1, reads2;
    reads1 = (id_op != JAL);
    reads2 = (id_op == R) || (id_op == SW) || (id_op == BEQ);
    if (id_flush || !m_ex[i].mem_read || m_ex[i].rd == 5'd0) return 1'b0;
    return (reads1 && m_ex[i].rd == id_rs1) || (reads2 && m_ex[i].rd == id_rs2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_ex[i] = zero_ex(); m_frozen[i] = 1'b0; m_ill[i] = 1'b0; m_sc[i] = 0; m_bc[i] = 0;
    end
  endtask

  task automatic m_clock();
    ex_t e;
    bit  ok;
    for (int i = 0; i < 2; i++) begin
      if (!m_pcw[i]) m_sc[i] = (m_sc[i] < m_max[i]) ? m_sc[i] + 1 : m_sc[i];
      if (m_frozen[i]) begin
        if (!id_stall) m_frozen[i] = 1'b0;   // release cycle: nothing captured
      end else if (id_stall) begin
        m_frozen[i] = 1'b1;
      end else begin
        ok = m_decode(id_op, m_je[i], id_rd, e);
        if (id_flush || m_hz[i] || !ok) begin
          m_ex[i] = zero_ex();
          m_bc[i] = (m_bc[i] < m_max[i]) ? m_bc[i] + 1 : m_bc[i];
          if (!id_flush && !m_hz[i] && !ok) m_ill[i] = 1'b1;
        end else begin
          m_ex[i] = e;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  logic last_hz, last_pcw;

  task automatic chk_regs(input int i);
    string p;
    p = (i == 0) ? "d0" : "d1";
    chk({p, "_alu_op"},   32'(obs[i].ex.alu_op),    32'(m_ex[i].alu_op));
    chk({p, "_alu_src"},  32'(obs[i].ex.alu_src),   32'(m_ex[i].alu_src));
    chk({p, "_reg_wr"},   32'(obs[i].ex.reg_write), 32'(m_ex[i].reg_write));
    chk({p, "_mem_rd"},   32'(obs[i].ex.mem_read),  32'(m_ex[i].mem_read));
    chk({p, "_mem_wr"},   32'(obs[i].ex.mem_write), 32'(m_ex[i].mem_write));
    chk({p, "_branch"},   32'(obs[i].ex.branch),    32'(m_ex[i].branch));
    chk({p, "_jump"},     32'(obs[i].ex.jump),      32'(m_ex[i].jump));
    chk({p, "_wb_sel"},   32'(obs[i].ex.wb_sel),    32'(m_ex[i].wb_sel));
    chk({p, "_rd"},       32'(obs[i].ex.rd),        32'(m_ex[i].rd));
    chk({p, "_illegal"},  32'(obs[i].ill),          32'(m_ill[i]));
    chk({p, "_stall_cnt"}, 32'(obs[i].sc),          32'(m_sc[i]));
    chk({p, "_bub_cnt"},  32'(obs[i].bc),           32'(m_bc[i]));
    chk({p, "_state"},    32'(obs[i].st),           32'(m_frozen[i]));
  endtask

  // One clock: drive at posedge+1, check combinational outputs at posedge+2,
  // clock, then check registered outputs at posedge+1.
  task automatic cyc(input logic [6:0] op, input int rs1, input int rs2, input int rd,
                     input logic st, input logic fl);
    id_op = op; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    id_stall = st; id_flush = fl;
    #1;
    for (int i = 0; i < 2; i++) begin
      m_hz[i]  = m_hazard(i);
      m_pcw[i] = !(id_stall || m_hz[i] || m_frozen[i]);
      chk((i == 0) ? "d0_hazard" : "d1_hazard", 32'(obs[i].hz),  32'(m_hz[i]));
      chk((i == 0) ? "d0_pc_wr"  : "d1_pc_wr",  32'(obs[i].pcw), 32'(m_pcw[i]));
      chk((i == 0) ? "d0_ifid"   : "d1_ifid",   32'(obs[i].ifw), 32'(m_pcw[i]));
    end
    last_hz = d0_hz; last_pcw = d0_pcw;
    @(posedge clk);
    m_clock();
    #1;
    chk_regs(0);
    chk_regs(1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [6:0] op;
    int         rs1, rs2, rd;
    logic       st, fl;
    logic       e_hz, e_pcw;
    logic [1:0] e_alu;
    logic       e_rw, e_mr;
    logic [1:0] e_wb;
    logic [4:0] e_rd;
  } vec_t;

  vec_t tbl[16];
  int   n_vec = 0;

  task automatic add_vec(input logic [6:0] op, input int rs1, input int rs2, input int rd,
                         input int eh, input int ep, input int ealu, input int erw,
                         input int emr, input int ewb, input int erd, input int fl);
    tbl[n_vec] = '{op, rs1, rs2, rd, 1'b0, 1'(fl), 1'(eh), 1'(ep), 2'(ealu),
                   1'(erw), 1'(emr), 2'(ewb), 5'(erd)};
    n_vec++;
  endtask

  logic [6:0] rand_ops[8];
  int         s0, r0;

  initial begin
    rand_ops[0] = R;  rand_ops[1] = I;   rand_ops[2] = LW;  rand_ops[3] = SW;
    rand_ops[4] = BEQ; rand_ops[5] = JAL; rand_ops[6] = JALR; rand_ops[7] = 7'b1111111;

    //        op   rs1 rs2 rd  hz pcw alu rw mr wb rd  flush
    add_vec(R,    1,  2,  3,  0, 1,  2,  1, 0, 0, 3,  0);  // first decode, 1-cycle latency
    add_vec(LW,   1,  0,  5,  0, 1,  0,  1, 1, 1, 5,  0);
    add_vec(R,    1,  5,  6,  1, 0,  0,  0, 0, 0, 0,  0);  // load-use on rs2: bubble
    add_vec(R,    1,  5,  6,  0, 1,  2,  1, 0, 0, 6,  0);  // held ADD captured
    add_vec(LW,   2,  0,  0,  0, 1,  0,  1, 1, 1, 0,  0);  // load to x0
    add_vec(R,    0,  0,  7,  0, 1,  2,  1, 0, 0, 7,  0);  // use of x0: no hazard
    add_vec(LW,   1,  0,  4,  0, 1,  0,  1, 1, 1, 4,  0);
    add_vec(SW,   2,  4,  0,  0, 1,  0,  0, 0, 0, 0,  1);  // flush + hazard: one bubble
    add_vec(JAL,  4,  0,  1,  0, 1,  0,  0, 0, 0, 0,  0);  // JAL illegal in d0
    add_vec(I,    1,  0,  2,  0, 1,  3,  1, 0, 0, 2,  0);
    add_vec(LW,   0,  0,  9,  0, 1,  0,  1, 1, 1, 9,  0);
    add_vec(BEQ,  3,  9,  0,  1, 0,  0,  0, 0, 0, 0,  0);  // BEQ reads rs2
    add_vec(BEQ,  3,  9,  0,  0, 1,  1,  0, 0, 0, 0,  0);
    add_vec(LW,   1,  0,  8,  0, 1,  0,  1, 1, 1, 8,  0);
    add_vec(JAL,  8,  8,  1,  0, 1,  0,  0, 0, 0, 0,  0);  // JAL never compares rs1
    add_vec(I,    0,  0,  0,  0, 1,  3,  1, 0, 0, 0,  0);

    // reset, with mem_stall high to show the enables are forced on
    rst_n = 1'b0;
    id_op = I; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_stall = 1'b1; id_flush = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_pc_wr", 32'(obs[i].pcw), 32'd1);
      chk("rst_ifid",  32'(obs[i].ifw), 32'd1);
      chk("rst_hazard", 32'(obs[i].hz), 32'd0);
      chk_regs(i);
    end
    id_stall = 1'b0;
    rst_n = 1'b1;

    for (int k = 0; k < n_vec; k++) begin
      cyc(tbl[k].op, tbl[k].rs1, tbl[k].rs2, tbl[k].rd, tbl[k].st, tbl[k].fl);
      chk($sformatf("tbl%0d_hazard", k), 32'(last_hz),  32'(tbl[k].e_hz));
      chk($sformatf("tbl%0d_pc_wr", k),  32'(last_pcw), 32'(tbl[k].e_pcw));
      chk($sformatf("tbl%0d_alu", k),    32'(d0_alu),   32'(tbl[k].e_alu));
      chk($sformatf("tbl%0d_rw", k),     32'(d0_rw),    32'(tbl[k].e_rw));
      chk($sformatf("tbl%0d_mr", k),     32'(d0_mr),    32'(tbl[k].e_mr));
      chk($sformatf("tbl%0d_wb", k),     32'(d0_wb),    32'(tbl[k].e_wb));
      chk($sformatf("tbl%0d_rd", k),     32'(d0_rd),    32'(tbl[k].e_rd));
    end
    chk("ill_sticky", 32'(d0_ill), 32'd1);

    // mem_stall for 4 cycles: EX frozen through the stall and its release cycle
    cyc(R, 1, 2, 11, 1'b0, 1'b0);
    s0 = int'(d0_sc);
    r0 = int'(d0_rd);
    for (int k = 0; k < 4; k++) begin
      cyc(R, 1, 2, 12 + k, 1'b1, 1'b0);
      chk("stall_pc_wr", 32'(last_pcw), 32'd0);
      chk("stall_frozen_rd", 32'(d0_rd), 32'(r0));
    end
    cyc(R, 1, 2, 20, 1'b0, 1'b0);
    chk("release_pc_wr", 32'(last_pcw), 32'd0);
    chk("release_frozen_rd", 32'(d0_rd), 32'(r0));
    chk("stall_cnt_delta", 32'(int'(d0_sc) - s0), 32'd5);
    cyc(R, 1, 2, 21, 1'b0, 1'b0);
    chk("resume_rd", 32'(d0_rd), 32'd21);

    // JALR / JAL with jumps enabled (d1)
    cyc(JALR, 2, 0, 1, 1'b0, 1'b0);
    chk("jalr_jump", 32'(d1_jp), 32'd1);
    chk("jalr_wb",   32'(d1_wb), 32'd2);
    chk("jalr_src",  32'(d1_src), 32'd1);
    chk("jalr_d0_rd", 32'(d0_rd), 32'd0);
    cyc(JAL, 2, 0, 1, 1'b0, 1'b0);
    chk("jal_src",  32'(d1_src), 32'd0);
    chk("jal_jump", 32'(d1_jp), 32'd1);

    // reset asserted mid-HOLD clears everything without a clock edge
    cyc(LW, 1, 0, 6, 1'b0, 1'b0);
    cyc(R, 1, 2, 7, 1'b1, 1'b0);
    cyc(R, 1, 2, 7, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    m_reset();
    for (int i = 0; i < 2; i++) begin
      chk("midhold_pc_wr", 32'(obs[i].pcw), 32'd1);
      chk("midhold_hazard", 32'(obs[i].hz), 32'd0);
      chk_regs(i);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    id_stall = 1'b0;

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      cyc(rand_ops[$urandom_range(7)], $urandom_range(3), $urandom_range(3), $urandom_range(3),
          ($urandom_range(5) == 0), ($urandom_range(7) == 0));
    end

    // long stall burst: the 4-bit counter must sit at all-ones
    for (int k = 0; k < 20; k++) cyc(R, 1, 2, 3, 1'b1, 1'b0);
    cyc(R, 1, 2, 3, 1'b0, 1'b0);
    chk("d1_stall_sat", 32'(d1_sc), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
